// File: rtl/imm_narrower_16in_12out_pkg.sv
// Shared processor constants for immediate-field narrowing and the
// occupancy encoding of the 2-entry output buffer.
package imm_narrower_16in_12out_pkg;

    localparam int WORD_W  = 16;
    localparam int IMM12_W = 12;

    localparam logic [IMM12_W-1:0] IMM12_MAX = 12'h7FF;
    localparam logic [IMM12_W-1:0] IMM12_MIN = 12'h800;

    localparam logic [1:0] FIFO_EMPTY = 2'd0;
    localparam logic [1:0] FIFO_ONE   = 2'd1;
    localparam logic [1:0] FIFO_FULL  = 2'd2;

endpackage

// File: rtl/imm_narrower_16in_12out_narrow_fifo2.sv
// Generic 2-entry register FIFO, valid/ready on both sides. All outputs come
// straight from flops, so out_ready never reaches in_ready combinationally.
module narrow_fifo2
    import imm_narrower_16in_12out_pkg::*;
#(
    parameter int W = 13
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready
);

    logic [1:0]   state;
    logic [W-1:0] head;
    logic [W-1:0] tail;
    logic         accept;
    logic         pop;

    assign in_ready  = (state != FIFO_FULL);
    assign out_valid = (state != FIFO_EMPTY);
    assign out_data  = head;
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FIFO_EMPTY;
            head  <= '0;
            tail  <= '0;
        end else begin
            case (state)
                FIFO_EMPTY: begin
                    if (accept) begin
                        head  <= in_data;
                        state <= FIFO_ONE;
                    end
                end
                FIFO_ONE: begin
                    if (accept && pop) begin
                        head <= in_data;
                    end else if (accept) begin
                        tail  <= in_data;
                        state <= FIFO_FULL;
                    end else if (pop) begin
                        state <= FIFO_EMPTY;
                    end
                end
                FIFO_FULL: begin
                    if (pop) begin
                        head  <= tail;
                        state <= FIFO_ONE;
                    end
                end
                default: state <= FIFO_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/imm_narrower_16in_12out.sv
// Narrows signed datapath words into signed immediate fields with saturate or
// wrap on overflow, buffers {result, ovf} pairs, and keeps overflow statistics.
module imm_narrower_16in_12out
    import imm_narrower_16in_12out_pkg::*;
#(
    parameter int IN_W  = WORD_W,
    parameter int OUT_W = IMM12_W,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             in_ready,
    input  logic             sat_en,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf,
    input  logic             out_ready,
    input  logic             clear_stats,
    output logic             sticky_ovf,
    output logic [CNT_W-1:0] ovf_count
);

    // Representable iff every bit from the sign down to the output sign bit agrees.
    localparam int HI_W = IN_W - OUT_W + 1;

    localparam logic [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    logic [HI_W-1:0]  hi_bits;
    logic             ovf;
    logic [OUT_W-1:0] result;
    logic             accept;

    assign hi_bits = in_data[IN_W-1:OUT_W-1];
    assign ovf     = !((hi_bits == '0) || (hi_bits == '1));
    assign accept  = in_valid && in_ready;

    always_comb begin
        result = in_data[OUT_W-1:0];
        if (ovf && sat_en)
            result = in_data[IN_W-1] ? SAT_MIN : SAT_MAX;
    end

    narrow_fifo2 #(.W(OUT_W + 1)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   ({result, ovf}),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  ({out_data, out_ovf}),
        .out_ready (out_ready)
    );

    // clear_stats wins over a same-cycle overflowing accept.
    always_ff @(posedge clk) begin
        if (reset || clear_stats) begin
            sticky_ovf <= 1'b0;
            ovf_count  <= '0;
        end else if (accept && ovf) begin
            sticky_ovf <= 1'b1;
            if (ovf_count != '1)
                ovf_count <= ovf_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_imm_narrower_16in_12out.sv
// Directed bench for imm_narrower_16in_12out: range boundaries, saturate/wrap,
// backpressure ordering, counter saturation, clear priority and mid-run reset.
module tb_imm_narrower_16in_12out;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        sat_en;
    logic        out_valid;
    logic [11:0] out_data;
    logic        out_ovf;
    logic        out_ready;
    logic        clear_stats;
    logic        sticky_ovf;
    logic [7:0]  ovf_count;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    imm_narrower_16in_12out dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .sat_en      (sat_en),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ovf     (out_ovf),
        .out_ready   (out_ready),
        .clear_stats (clear_stats),
        .sticky_ovf  (sticky_ovf),
        .ovf_count   (ovf_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1ns past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [11:0] d, input logic o);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"}, 32'(out_data), 32'(d));
        chk({tag, "_ovf"}, 32'(out_ovf), 32'(o));
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; sat_en = 1'b1;
        out_ready = 1'b1; clear_stats = 1'b0;
        step(); step();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_ovf", 32'(out_ovf), 32'd0);
        chk("rst_sticky", 32'(sticky_ovf), 32'd0);
        chk("rst_count", 32'(ovf_count), 32'd0);
        reset = 1'b0;

        // In-range values including both boundaries, one cycle latency.
        in_valid = 1'b1;
        in_data = 16'h0003; step(); chk_out("inr_0003", 12'h003, 1'b0);
        in_data = 16'hF803; step(); chk_out("inr_F803", 12'h803, 1'b0);
        in_data = 16'h07FF; step(); chk_out("inr_07FF", 12'h7FF, 1'b0);
        in_data = 16'hF800; step(); chk_out("inr_F800", 12'h800, 1'b0);
        in_valid = 1'b0; step();
        chk("inr_drained", 32'(out_valid), 32'd0);
        chk("inr_count", 32'(ovf_count), 32'd0);
        chk("inr_sticky", 32'(sticky_ovf), 32'd0);

        // Saturation.
        in_valid = 1'b1; sat_en = 1'b1;
        in_data = 16'h0800; step(); chk_out("sat_0800", 12'h7FF, 1'b1);
        in_data = 16'h8000; step(); chk_out("sat_8000", 12'h800, 1'b1);
        chk("sat_sticky", 32'(sticky_ovf), 32'd1);
        chk("sat_count", 32'(ovf_count), 32'd2);

        // Wrap.
        sat_en = 1'b0;
        in_data = 16'h0800; step(); chk_out("wrap_0800", 12'h800, 1'b1);
        in_data = 16'hF7FF; step(); chk_out("wrap_F7FF", 12'h7FF, 1'b1);
        chk("wrap_count", 32'(ovf_count), 32'd4);
        in_valid = 1'b0; step();

        // Backpressure: two accepts fill the buffer, third is held off.
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 16'h0001; step(); chk_out("bp_a1", 12'h001, 1'b0);
        chk("bp_ready_one", 32'(in_ready), 32'd1);
        in_data = 16'h0002; step(); chk_out("bp_a2", 12'h001, 1'b0);
        chk("bp_ready_full", 32'(in_ready), 32'd0);
        in_data = 16'h0003; step(); chk_out("bp_hold", 12'h001, 1'b0);
        chk("bp_still_full", 32'(in_ready), 32'd0);
        out_ready = 1'b1; step(); chk_out("bp_pop2", 12'h002, 1'b0);
        chk("bp_ready_again", 32'(in_ready), 32'd1);
        step(); chk_out("bp_pop3", 12'h003, 1'b0);
        in_valid = 1'b0; step();
        chk("bp_empty", 32'(out_valid), 32'd0);
        chk("bp_count", 32'(ovf_count), 32'd4);

        // Counter saturation.
        sat_en = 1'b1; in_valid = 1'b1; in_data = 16'h0800;
        for (int i = 0; i < 300; i++) step();
        chk("cnt_sat", 32'(ovf_count), 32'd255);
        chk("cnt_sticky", 32'(sticky_ovf), 32'd1);

        // Clear beats a same-cycle overflowing accept; entry keeps its flag.
        in_data = 16'h8000; clear_stats = 1'b1; step();
        chk_out("clr_entry", 12'h800, 1'b1);
        chk("clr_sticky", 32'(sticky_ovf), 32'd0);
        chk("clr_count", 32'(ovf_count), 32'd0);
        clear_stats = 1'b0; in_valid = 1'b0; step();
        chk("clr_count_hold", 32'(ovf_count), 32'd0);
        chk("clr_empty", 32'(out_valid), 32'd0);

        // Fill, then reset with an overflowing accept in flight.
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 16'h0011; step();
        in_data = 16'h0022; step();
        chk("fr_full", 32'(in_ready), 32'd0);
        in_data = 16'h0800; reset = 1'b1;
        out_ready = 1'b1; step();
        chk("fr_out_valid", 32'(out_valid), 32'd0);
        chk("fr_in_ready", 32'(in_ready), 32'd1);
        chk("fr_out_data", 32'(out_data), 32'd0);
        chk("fr_sticky", 32'(sticky_ovf), 32'd0);
        chk("fr_count", 32'(ovf_count), 32'd0);
        reset = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fr_no_stale", 32'(out_valid), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/imm_narrower_16in_12out.md
Name: imm_narrower_16in_12out

Overview:
- Narrows 16-bit signed datapath values back into 12-bit signed immediate/offset fields, for example when the assembler-side or branch-offset logic re-encodes computed values into instruction fields.
- It is the inverse of the 12-to-16 sign extender.
- Range check: a value is representable iff bits [15:11] are all equal. Out-of-range values are saturated or wrapped, and flagged.
- Streams over a valid/ready handshake through a 2-entry buffer, and keeps sticky overflow statistics.

Parameters:
- IN_W, 16, input width.
- OUT_W, 12, output width. Must be less than IN_W.
- CNT_W, 8, width of the overflow event counter.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream value is present.
- in_data  in  IN_W  signed value to narrow.
- in_ready  out  1  buffer can accept a value this cycle.
- sat_en  in  1  1 = saturate on overflow, 0 = wrap (keep low OUT_W bits). Sampled at acceptance.
- out_valid  out  1  buffer head is valid.
- out_data  out  OUT_W  narrowed value at the buffer head.
- out_ovf  out  1  the head entry overflowed.
- out_ready  in  1  downstream takes the head this cycle.
- clear_stats  in  1  clears sticky_ovf and ovf_count.
- sticky_ovf  out  1  set by any accepted overflowing value.
- ovf_count  out  CNT_W  count of accepted overflowing values; saturates at all-ones.

Behaviour:
- Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- Narrowing, computed combinationally at accept:
  - ovf = ~(in_data[15:11] all equal).
  - If ovf = 0: result = in_data[11:0].
  - If ovf = 1 and sat_en = 1: result = 12'h7FF when in_data[15] = 0; 12'h800 when in_data[15] = 1.
  - If ovf = 1 and sat_en = 0: result = in_data[11:0].
  - The {result, ovf} pair is stored as one buffer entry.
- Buffer: 2-entry FIFO with occupancy states EMPTY (0), ONE (1), FULL (2).
  - Outputs are driven from registers only. in_ready = (state != FULL). out_valid = (state != EMPTY).
  - There is no combinational path from out_ready to in_ready.
- Occupancy transitions:
  - EMPTY: accept -> ONE.
  - ONE: accept & ~pop -> FULL. Pop & ~accept -> EMPTY. Accept & pop -> ONE; the new entry becomes the head next cycle.
  - FULL: pop -> ONE. No accept is possible.
- Latency: a value accepted in cycle N appears on out_data with out_valid = 1 in cycle N+1 if the buffer was empty. Order is strictly FIFO.
- While out_valid = 1 and out_ready = 0, out_data and out_ovf hold stable.
- Throughput: 1 value per cycle when out_ready is held high.
- Statistics:
  - An accept with ovf = 1 sets sticky_ovf and increments ovf_count. The count holds at 2^CNT_W-1 and does not wrap.
  - clear_stats has priority: in a cycle with clear_stats = 1, both clear to 0 even if an overflowing accept occurs that same cycle. That value is still buffered with out_ovf = 1.
  - Stats are independent of pops.
- Reset values: in_ready = 1, out_valid = 0, out_data = 0, out_ovf = 0, sticky_ovf = 0, ovf_count = 0.
- Reset mid-operation drops all buffered entries. Any in-flight accept in the reset cycle is discarded.
- Boundary values:
  - -2048 (16'hF800) and 2047 (16'h07FF) are in range.
  - 2048 (16'h0800) and -2049 (16'hF7FF) overflow.

Decomposition:
- Shared package (processor package) holds the width constants IMM12_W = 12 and WORD_W = 16, plus the saturation constants IMM12_MAX = 12'h7FF and IMM12_MIN = 12'h800.
- One natural sub-module, narrow_fifo2: the generic 2-entry register FIFO with valid/ready on both sides, width OUT_W+1.
- The narrowing arithmetic and the statistics stay in the top module.

Test Plan:
- After reset, sat_en = 1, push 16'h0003, 16'hF803, 16'h07FF, 16'hF800 with out_ready = 1 -> out_data = 12'h003, 12'h803, 12'h7FF, 12'h800 on consecutive cycles, each with out_ovf = 0, one cycle after its accept; ovf_count = 0.
- sat_en = 1, push 16'h0800, then 16'h8000 -> out_data = 12'h7FF then 12'h800, out_ovf = 1 on both; sticky_ovf = 1, ovf_count = 2.
- sat_en = 0, push 16'h0800, then 16'hF7FF -> out_data = 12'h800 then 12'h7FF, out_ovf = 1 on both.
- out_ready = 0, drive in_valid = 1 with 16'h0001, 16'h0002, 16'h0003:
  - in_ready falls after 2 accepts and 16'h0003 is held off.
  - out_data stays at 12'h001.
  - Raising out_ready -> output sequence 001, 002, 003 in order, with no loss or duplication.
- 300 overflowing accepts -> ovf_count = 255. Then clear_stats = 1 in the same cycle as an overflowing accept -> sticky_ovf = 0 and ovf_count = 0 next cycle, while that entry still emerges with out_ovf = 1.
- Buffer FULL, then reset = 1 for one cycle -> next cycle out_valid = 0, in_ready = 1, all stats 0; no stale entry emerges afterward.
